// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types, opcode constants and decode helpers for the EX/MEM stage
package exec_pkg;

  typedef enum logic [1:0] {
    CLS_INT     = 2'b00,
    CLS_FIXED   = 2'b01,
    CLS_VECTOR  = 2'b10,
    CLS_ILLEGAL = 2'b11
  } op_class_e;

  localparam logic [4:0] OP_INT_ADD = 5'b00_000;
  localparam logic [4:0] OP_INT_SUB = 5'b00_001;
  localparam logic [4:0] OP_INT_MUL = 5'b00_010;
  localparam logic [4:0] OP_FIX_ADD = 5'b01_000;
  localparam logic [4:0] OP_FIX_SUB = 5'b01_001;
  localparam logic [4:0] OP_FIX_MUL = 5'b01_010;
  localparam logic [4:0] OP_VEC_ADD = 5'b10_000;
  localparam logic [4:0] OP_VEC_SUB = 5'b10_001;
  localparam logic [4:0] OP_VEC_MUL = 5'b10_010;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic is_legal_op(input logic [4:0] opcode);
    return (opcode[4:3] != 2'b11) && (opcode[2:0] <= 3'd2);
  endfunction

  // Folds unsupported ops into CLS_ILLEGAL so callers need a single case.
  function automatic op_class_e op_class(input logic [4:0] opcode);
    return is_legal_op(opcode) ? op_class_e'(opcode[4:3]) : CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - Execution-to-EX/MEM bundle plus registered outputs and forwarding path
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int VECTOR_LENGTH  = 16,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic [4:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     Out_int;
  logic [DATA_WIDTH-1:0]     Out_fixed;
  logic [DATA_WIDTH-1:0]     Out_vector [VECTOR_LENGTH-1:0];
  logic                      C_int, N_int, V_int, Z_int;
  logic                      C_fixed, N_fixed, V_fixed, Z_fixed;
  logic [VECTOR_LENGTH-1:0]  C_vector, N_vector, V_vector, Z_vector;
  logic                      clr_sticky;

  logic                      out_valid;
  logic [1:0]                out_class;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_wr_en;
  logic [DATA_WIDTH-1:0]     out_scalar;
  logic [DATA_WIDTH-1:0]     out_vector [VECTOR_LENGTH-1:0];
  logic [3:0]                flags_nzcv;
  logic [3:0]                vflags_nzcv [VECTOR_LENGTH-1:0];
  logic                      illegal_op;
  logic [15:0]               retired_cnt;
  logic                      sticky_v;

  logic                      fwd_valid;
  logic [REG_ADDR_WIDTH-1:0] fwd_rd;
  logic [DATA_WIDTH-1:0]     fwd_scalar;
  logic [DATA_WIDTH-1:0]     fwd_vector [VECTOR_LENGTH-1:0];

  modport master (
    output stall, flush, in_valid, opcode, rd, wr_en,
    output Out_int, Out_fixed, Out_vector,
    output C_int, N_int, V_int, Z_int, C_fixed, N_fixed, V_fixed, Z_fixed,
    output C_vector, N_vector, V_vector, Z_vector, clr_sticky,
    input  out_valid, out_class, out_rd, out_wr_en, out_scalar, out_vector,
    input  flags_nzcv, vflags_nzcv, illegal_op, retired_cnt, sticky_v,
    input  fwd_valid, fwd_rd, fwd_scalar, fwd_vector
  );

  modport slave (
    input  stall, flush, in_valid, opcode, rd, wr_en,
    input  Out_int, Out_fixed, Out_vector,
    input  C_int, N_int, V_int, Z_int, C_fixed, N_fixed, V_fixed, Z_fixed,
    input  C_vector, N_vector, V_vector, Z_vector, clr_sticky,
    output out_valid, out_class, out_rd, out_wr_en, out_scalar, out_vector,
    output flags_nzcv, vflags_nzcv, illegal_op, retired_cnt, sticky_v,
    output fwd_valid, fwd_rd, fwd_scalar, fwd_vector
  );

endinterface

// File: rtl/vector_flag_bank.sv
// rtl/vector_flag_bank.sv - per-lane NZCV status registers with a common load enable
module vector_flag_bank
  import exec_pkg::*;
#(
  parameter int VECTOR_LENGTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load_i,
  input  nzcv_t flags_i [VECTOR_LENGTH-1:0],
  output nzcv_t flags_o [VECTOR_LENGTH-1:0]
);

  nzcv_t bank_q [VECTOR_LENGTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '{default: '0};
    end else if (load_i) begin
      bank_q <= flags_i;
    end
  end

  assign flags_o = bank_q;

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register, status flags and forwarding path
// Optional sticky overflow tracking is enabled by defining STICKY_V_EN.
module ex_mem_stage
  import exec_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int VECTOR_LENGTH  = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  op_class_e cls;
  logic      accept;
  logic      acc_legal;
  logic      vec_load;

  assign cls       = op_class(bus.opcode);
  assign accept    = bus.in_valid & ~bus.stall & ~bus.flush;
  assign acc_legal = accept & (cls != CLS_ILLEGAL);
  assign vec_load  = acc_legal & (cls == CLS_VECTOR);

  logic                      valid_q, valid_d;
  op_class_e                 class_q, class_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      wr_q, wr_d;
  logic [DATA_WIDTH-1:0]     scalar_q, scalar_d;
  nzcv_t                     flags_q, flags_d;
  logic                      ill_q, ill_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0]     vec_q [VECTOR_LENGTH-1:0];
  nzcv_t                     vflags_in [VECTOR_LENGTH-1:0];
  nzcv_t                     vflags_q [VECTOR_LENGTH-1:0];

  // Flush wins over stall; a stall freezes everything except the illegal pulse.
  always_comb begin
    valid_d  = valid_q;
    class_d  = class_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    scalar_d = scalar_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    ill_d    = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = acc_legal;
      ill_d   = bus.in_valid & (cls == CLS_ILLEGAL);
      if (acc_legal) begin
        class_d = cls;
        rd_d    = bus.rd;
        wr_d    = bus.wr_en;
        cnt_d   = cnt_q + 16'd1;
        case (cls)
          CLS_INT: begin
            scalar_d = bus.Out_int;
            flags_d  = {bus.N_int, bus.Z_int, bus.C_int, bus.V_int};
          end
          CLS_FIXED: begin
            scalar_d = bus.Out_fixed;
            flags_d  = {bus.N_fixed, bus.Z_fixed, bus.C_fixed, bus.V_fixed};
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STICKY_V_EN
  logic v_sel;

  always_comb begin
    case (cls)
      CLS_INT:    v_sel = bus.V_int;
      CLS_FIXED:  v_sel = bus.V_fixed;
      CLS_VECTOR: v_sel = |bus.V_vector;
      default:    v_sel = 1'b0;
    endcase
  end

  // A clear in the same cycle as a new overflow takes precedence.
  always_comb begin
    sticky_d = sticky_q;
    if (acc_legal && v_sel) sticky_d = 1'b1;
    if (bus.clr_sticky) sticky_d = 1'b0;
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = bus.clr_sticky;
  assign sticky_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      class_q  <= CLS_INT;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      scalar_q <= '0;
      flags_q  <= '0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      class_q  <= class_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      scalar_q <= scalar_d;
      flags_q  <= flags_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '{default: '0};
    end else if (vec_load) begin
      vec_q <= bus.Out_vector;
    end
  end

  always_comb begin
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      vflags_in[i] = {bus.N_vector[i], bus.Z_vector[i], bus.C_vector[i], bus.V_vector[i]};
    end
  end

  vector_flag_bank #(
    .VECTOR_LENGTH(VECTOR_LENGTH)
  ) u_vflags (
    .clk    (clk),
    .rst    (rst),
    .load_i (vec_load),
    .flags_i(vflags_in),
    .flags_o(vflags_q)
  );

  assign bus.out_valid   = valid_q;
  assign bus.out_class   = class_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wr_en   = wr_q & valid_q;
  assign bus.out_scalar  = scalar_q;
  assign bus.out_vector  = vec_q;
  assign bus.flags_nzcv  = flags_q;
  assign bus.illegal_op  = ill_q;
  assign bus.retired_cnt = cnt_q;
  assign bus.sticky_v    = sticky_q;

  for (genvar g = 0; g < VECTOR_LENGTH; g++) begin : g_vflags
    assign bus.vflags_nzcv[g] = vflags_q[g];
  end

  assign bus.fwd_valid  = valid_q & wr_q;
  assign bus.fwd_rd     = rd_q;
  assign bus.fwd_scalar = scalar_q;
  assign bus.fwd_vector = vec_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage with a behavioural reference model
module tb_ex_mem_stage;
  import exec_pkg::*;

  localparam int DW = 16;
  localparam int VL = 16;
  localparam int RW = 4;
`ifdef STICKY_V_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .REG_ADDR_WIDTH(RW)) bus ();

  ex_mem_stage #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic                   valid;
    logic [1:0]             cls;
    logic [RW-1:0]          rd;
    logic                   wr;
    logic [DW-1:0]          scalar;
    logic [VL-1:0][DW-1:0]  vec;
    logic [3:0]             flags;
    logic [VL-1:0][3:0]     vflags;
    logic                   ill;
    logic [15:0]            cnt;
    logic                   sticky;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [4:0] legal_ops [9];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference model: architectural effect of one clock edge given current inputs.
  task automatic model_step();
    int cls, op;
    logic vsel;
    if (rst) begin
      m = '0;
      return;
    end
    m.ill = 1'b0;
    if (bus.flush) begin
      m.valid = 1'b0;
    end else if (bus.stall) begin
      m.valid = m.valid;
    end else if (!bus.in_valid) begin
      m.valid = 1'b0;
    end else begin
      cls = int'(bus.opcode) / 8;
      op  = int'(bus.opcode) % 8;
      if (cls > 2 || op > 2) begin
        m.valid = 1'b0;
        m.ill   = 1'b1;
      end else begin
        m.valid = 1'b1;
        m.cls   = 2'(cls);
        m.rd    = bus.rd;
        m.wr    = bus.wr_en;
        m.cnt   = 16'((int'(m.cnt) + 1) % 65536);
        vsel    = 1'b0;
        if (cls == 0) begin
          m.scalar = bus.Out_int;
          m.flags  = {bus.N_int, bus.Z_int, bus.C_int, bus.V_int};
          vsel     = bus.V_int;
        end else if (cls == 1) begin
          m.scalar = bus.Out_fixed;
          m.flags  = {bus.N_fixed, bus.Z_fixed, bus.C_fixed, bus.V_fixed};
          vsel     = bus.V_fixed;
        end else begin
          for (int i = 0; i < VL; i++) begin
            m.vec[i]    = bus.Out_vector[i];
            m.vflags[i] = {bus.N_vector[i], bus.Z_vector[i], bus.C_vector[i], bus.V_vector[i]};
            if (bus.V_vector[i]) vsel = 1'b1;
          end
        end
        if (STICKY_EN && vsel) m.sticky = 1'b1;
      end
    end
    if (STICKY_EN && bus.clr_sticky) m.sticky = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    sb_q.push_back(m);
    #1;
  endtask

  task automatic set_idle();
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.opcode = '0; bus.rd = '0;
    bus.wr_en = 0; bus.clr_sticky = 0; bus.Out_int = '0; bus.Out_fixed = '0;
    {bus.C_int, bus.N_int, bus.V_int, bus.Z_int} = '0;
    {bus.C_fixed, bus.N_fixed, bus.V_fixed, bus.Z_fixed} = '0;
    bus.C_vector = '0; bus.N_vector = '0; bus.V_vector = '0; bus.Z_vector = '0;
    for (int i = 0; i < VL; i++) bus.Out_vector[i] = '0;
  endtask

  task automatic rand_data();
    bus.rd = 4'($urandom); bus.wr_en = 1'($urandom);
    bus.Out_int = 16'($urandom); bus.Out_fixed = 16'($urandom);
    {bus.C_int, bus.N_int, bus.V_int, bus.Z_int} = 4'($urandom);
    {bus.C_fixed, bus.N_fixed, bus.V_fixed, bus.Z_fixed} = 4'($urandom);
    bus.C_vector = 16'($urandom); bus.N_vector = 16'($urandom);
    bus.V_vector = 16'($urandom_range(0, 3) == 0 ? $urandom : 0);
    bus.Z_vector = 16'($urandom);
    for (int i = 0; i < VL; i++) bus.Out_vector[i] = 16'($urandom);
  endtask

  // Monitor: every edge the stage presents a new state; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_valid", 64'(bus.out_valid), 64'(e.valid));
        check("out_wr_en", 64'(bus.out_wr_en), 64'(e.valid & e.wr));
        check("fwd_valid", 64'(bus.fwd_valid), 64'(e.valid & e.wr));
        check("illegal_op", 64'(bus.illegal_op), 64'(e.ill));
        check("retired_cnt", 64'(bus.retired_cnt), 64'(e.cnt));
        check("flags_nzcv", 64'(bus.flags_nzcv), 64'(e.flags));
        check("sticky_v", 64'(bus.sticky_v), 64'(e.sticky));
        check("out_class", 64'(bus.out_class), 64'(e.cls));
        check("out_rd", 64'(bus.out_rd), 64'(e.rd));
        check("fwd_rd", 64'(bus.fwd_rd), 64'(e.rd));
        check("out_scalar", 64'(bus.out_scalar), 64'(e.scalar));
        check("fwd_scalar", 64'(bus.fwd_scalar), 64'(e.scalar));
        for (int i = 0; i < VL; i++) begin
          check($sformatf("out_vector[%0d]", i), 64'(bus.out_vector[i]), 64'(e.vec[i]));
          check($sformatf("fwd_vector[%0d]", i), 64'(bus.fwd_vector[i]), 64'(e.vec[i]));
          check($sformatf("vflags_nzcv[%0d]", i), 64'(bus.vflags_nzcv[i]), 64'(e.vflags[i]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    legal_ops = '{OP_INT_ADD, OP_INT_SUB, OP_INT_MUL, OP_FIX_ADD, OP_FIX_SUB,
                  OP_FIX_MUL, OP_VEC_ADD, OP_VEC_SUB, OP_VEC_MUL};
    m = '0;
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Integer ADD with overflow forwards straight to rd 3.
    bus.in_valid = 1; bus.opcode = OP_INT_ADD; bus.Out_int = 16'h7FFF;
    bus.V_int = 1; bus.rd = 4'd3; bus.wr_en = 1;
    cycle();
    check("t2_out_scalar", 64'(bus.out_scalar), 64'h7FFF);
    check("t2_flags", 64'(bus.flags_nzcv), 64'b0001);
    check("t2_fwd_valid", 64'(bus.fwd_valid), 64'd1);
    check("t2_fwd_rd", 64'(bus.fwd_rd), 64'd3);

    // Vector ADD held behind a three-cycle stall.
    set_idle();
    rand_data();
    bus.in_valid = 1; bus.opcode = OP_VEC_ADD; bus.stall = 1;
    bus.N_vector = '0; bus.C_vector = '0; bus.V_vector = '0; bus.Z_vector = 16'h0020;
    repeat (3) cycle();
    check("t3_frozen_valid", 64'(bus.out_valid), 64'd1);
    bus.stall = 0;
    cycle();
    check("t3_out_valid", 64'(bus.out_valid), 64'd1);
    check("t3_vflags5", 64'(bus.vflags_nzcv[5]), 64'b0100);
    check("t3_flags_held", 64'(bus.flags_nzcv), 64'b0001);

    // Unsupported op pulses illegal_op once.
    set_idle();
    bus.in_valid = 1; bus.opcode = 5'b00011;
    cycle();
    check("t4_illegal", 64'(bus.illegal_op), 64'd1);
    check("t4_out_valid", 64'(bus.out_valid), 64'd0);
    check("t4_cnt", 64'(bus.retired_cnt), 64'd2);
    set_idle();
    cycle();
    check("t4_pulse_end", 64'(bus.illegal_op), 64'd0);

    // Flush overrides a simultaneous stall.
    rand_data();
    bus.in_valid = 1; bus.opcode = OP_FIX_MUL; bus.flush = 1; bus.stall = 1;
    cycle();
    check("t5_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_flags", 64'(bus.flags_nzcv), 64'b0001);

    // Sticky overflow set then cleared.
    set_idle();
    bus.in_valid = 1; bus.opcode = OP_INT_SUB; bus.V_int = 1;
    cycle();
    check("t6_sticky_set", 64'(bus.sticky_v), 64'(STICKY_EN));
    set_idle();
    bus.clr_sticky = 1;
    cycle();
    check("t6_sticky_clr", 64'(bus.sticky_v), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      rand_data();
      rst          = ($urandom_range(0, 199) == 0);
      bus.in_valid = ($urandom_range(0, 99) < 85);
      bus.stall    = ($urandom_range(0, 99) < 15);
      bus.flush    = ($urandom_range(0, 99) < 8);
      bus.clr_sticky = !bus.stall && ($urandom_range(0, 99) < 5);
      bus.opcode   = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 8)] : 5'($urandom);
      cycle();
    end
    rst = 0;

    // Drive the counter up to its wrap point with back-to-back legal ops.
    set_idle();
    while (m.cnt != 16'hFFFF) begin
      rand_data();
      bus.in_valid = 1;
      bus.opcode   = legal_ops[$urandom_range(0, 8)];
      cycle();
    end
    check("cnt_at_max", 64'(bus.retired_cnt), 64'hFFFF);
    rand_data();
    bus.in_valid = 1; bus.opcode = OP_INT_MUL;
    cycle();
    check("cnt_wrap", 64'(bus.retired_cnt), 64'd0);

    set_idle();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
